// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and counter sizing for the serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// full_adder_bit: combinational one-bit full adder used once per RUN cycle
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract, one bit per cycle LSB first, valid/ready handshake
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    state_t          state, next;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
    logic            carry, ovf_r, s, co, last;

    full_adder_bit u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    assign last      = cnt == CW'(WIDTH - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign sum       = sum_sr;
    assign cout      = carry;
    assign ovf       = ovf_r;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    // next state: accept in IDLE, finish after WIDTH bits, release on out_ready
    always_comb begin
        next = state;
        if (state == IDLE && in_valid)       next = RUN;
        else if (state == RUN && last)       next = DONE;
        else if (state == DONE && out_ready) next = IDLE;
    end

    // datapath: load operands on accept, then shift one full-adder bit per RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            ovf_r  <= 1'b0;
            cnt    <= '0;
        end else if (state == IDLE && in_valid) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= {s, sum_sr[WIDTH-1:1]};
            carry  <= co;
            cnt    <= cnt + 1'b1;
            if (last) ovf_r <= carry ^ co;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomized checks of serial_adder against an arithmetic model
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int failures = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed range check for overflow
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                  input logic m, output logic [W-1:0] s, output logic co, output logic ov);
        int sx = int'($signed(x));
        int sy = int'($signed(y));
        int ux = int'(x);
        int uy = int'(y);
        int r;
        int t;
        if (m) begin
            t  = ux - uy;
            co = ux >= uy;
            r  = sx - sy;
        end else begin
            t  = ux + uy + int'(c);
            co = t > (1 << W) - 1;
            r  = sx + sy + int'(c);
        end
        s  = W'(t);
        ov = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endfunction

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
        @(negedge clk);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        chk("in_ready_busy", 64'(in_ready), 64'd0);
    endtask

    // Starts on the first falling edge after the accepting edge
    task automatic wait_done(input logic [W-1:0] es, input logic ec, input logic eo);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("latency_edges_after_accept", 64'(n), 64'(W));
        chk("sum", 64'(sum), 64'(es));
        chk("cout", 64'(cout), 64'(ec));
        chk("ovf", 64'(ovf), 64'(eo));
    endtask

    task automatic stall(input int cycles, input logic [W-1:0] es, input logic ec, input logic eo);
        for (int i = 0; i < cycles; i++) begin
            in_valid = 1'($urandom);
            a = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_sum", 64'(sum), 64'(es));
            chk("stall_cout_ovf", 64'({cout, ovf}), 64'({ec, eo}));
        end
        in_valid = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_out_valid", 64'(out_valid), 64'd0);
        chk("release_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic ts, input int stall_cycles);
        logic [W-1:0] es;
        logic ec, eo;
        model(ta, tb, tc, ts, es, ec, eo);
        issue(ta, tb, tc, ts);
        wait_done(es, ec, eo);
        stall(stall_cycles, es, ec, eo);
        release_out();
    endtask

    initial begin
        logic [W-1:0] es;
        logic ec, eo;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout_ovf", 64'({cout, ovf}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b1, 1'b0, 1);
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 0);
        run_op(8'h00, 8'h00, 1'b0, 1'b1, 0);

        // Stall in DONE with in_valid high; the request is taken only after DONE releases
        issue(8'h0F, 8'h01, 1'b0, 1'b0);
        wait_done(8'h10, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = W'(8'h20 + i);
            @(posedge clk);
            @(negedge clk);
            chk("hold_sum", 64'(sum), 64'h10);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
        end
        a = 8'h33; b = 8'h11; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hold_release_idle", 64'({in_ready, out_valid}), 64'b10);
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold_next_accepted", 64'(in_ready), 64'd0);
        wait_done(8'h44, 1'b0, 1'b0);
        release_out();

        // Reset mid-RUN abandons the operation at once
        issue(8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrun_rst_out_valid", 64'(out_valid), 64'd0);
        chk("midrun_rst_in_ready", 64'(in_ready), 64'd1);
        chk("midrun_rst_sum", 64'(sum), 64'd0);
        chk("midrun_rst_cout_ovf", 64'({cout, ovf}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 0);

        // Reset while a result is presented
        issue(8'h40, 8'h40, 1'b0, 1'b0);
        wait_done(8'h80, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("done_rst_out_valid", 64'(out_valid), 64'd0);
        chk("done_rst_sum", 64'(sum), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 0);

        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] ra, rb;
            logic rc, rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            if (i % 10 == 0) rb = (i % 20 == 0) ? ~ra : ra;
            model(ra, rb, rc, rs, es, ec, eo);
            issue(ra, rb, rc, rs);
            wait_done(es, ec, eo);
            stall(int'($urandom_range(0, 3)), es, ec, eo);
            release_out();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
